// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the core/host RAM arbiter.
package mem_arbiter_pkg;

    typedef enum logic {
        OWN_CORE,
        OWN_HOST
    } owner_e;

    localparam int unsigned PerfCntWidth = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PerfCntWidth-1:0] sat_inc(
        input logic [PerfCntWidth-1:0] val,
        input logic                    en
    );
        logic [PerfCntWidth-1:0] res;
        res = val;
        if (en && (val != '1)) begin
            res = val + 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the arbiter; slave is the arbiter view,
// master is the view of the requesters plus RAM.
interface mem_arbiter_if #(
    parameter int unsigned XLen   = 32,
    parameter int unsigned MemPos = 1024
);
    localparam int unsigned AddrWidth = $clog2(MemPos);

    logic                 core_req_i;
    logic                 core_we_i;
    logic [AddrWidth-1:0] core_addr_i;
    logic [XLen-1:0]      core_wdata_i;
    logic                 core_gnt_o;
    logic                 core_rvalid_o;
    logic [XLen-1:0]      core_rdata_o;

    logic                 host_req_i;
    logic                 host_we_i;
    logic [AddrWidth-1:0] host_addr_i;
    logic [XLen-1:0]      host_wdata_i;
    logic                 host_lock_i;
    logic                 host_gnt_o;
    logic                 host_rvalid_o;
    logic [XLen-1:0]      host_rdata_o;

    logic [AddrWidth-1:0] ram_a_o;
    logic                 ram_we_o;
    logic [XLen-1:0]      ram_wd_o;
    logic [XLen-1:0]      ram_rd_i;

    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o,
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i, host_lock_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o,
        output ram_a_o, ram_we_o, ram_wd_o,
        input  ram_rd_i
    );

    modport master (
        output core_req_i, core_we_i, core_addr_i, core_wdata_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o,
        output host_req_i, host_we_i, host_addr_i, host_wdata_i, host_lock_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o,
        input  ram_a_o, ram_we_o, ram_wd_o,
        output ram_rd_i
    );

endinterface

// File: rtl/mem_arbiter_perf.sv
// Saturating performance counters: core wait cycles and host grants.
module mem_arbiter_perf
    import mem_arbiter_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    core_wait_i,
    input  logic                    host_gnt_i,
    output logic [PerfCntWidth-1:0] core_stall_cnt_o,
    output logic [PerfCntWidth-1:0] host_xfer_cnt_o
);

    logic [PerfCntWidth-1:0] stall_cnt_q, stall_cnt_d;
    logic [PerfCntWidth-1:0] xfer_cnt_q,  xfer_cnt_d;

    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, core_wait_i);
        xfer_cnt_d  = sat_inc(xfer_cnt_q, host_gnt_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign core_stall_cnt_o = stall_cnt_q;
    assign host_xfer_cnt_o  = xfer_cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between the core and the host port.
// Optional counters enabled with MEM_ARBITER_PERF_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned XLen   = 32,
    parameter int unsigned MemPos = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    mem_arbiter_if.slave            bus,
    output logic [PerfCntWidth-1:0] core_stall_cnt_o,
    output logic [PerfCntWidth-1:0] host_xfer_cnt_o
);

    localparam int unsigned AddrWidth = $clog2(MemPos);

    owner_e               last_owner_q, last_owner_d;
    logic                 core_rvalid_q, core_rvalid_d;
    logic                 host_rvalid_q, host_rvalid_d;
    logic [XLen-1:0]      core_rdata_q, core_rdata_d;
    logic [XLen-1:0]      host_rdata_q, host_rdata_d;

    logic                 core_elig, host_elig;
    logic                 core_gnt, host_gnt;
    logic [AddrWidth-1:0] ram_a;
    logic                 ram_we;
    logic [XLen-1:0]      ram_wd;

    // Core wins when alone, or on a tie when the host owned the last grant.
    always_comb begin
        core_elig = bus.core_req_i & ~bus.host_lock_i;
        host_elig = bus.host_req_i;
        core_gnt  = core_elig & (~host_elig | (last_owner_q == OWN_HOST));
        host_gnt  = host_elig & ~core_gnt;
    end

    always_comb begin
        ram_a  = '0;
        ram_we = 1'b0;
        ram_wd = '0;
        if (core_gnt) begin
            ram_a  = bus.core_addr_i;
            ram_we = bus.core_we_i;
            ram_wd = bus.core_wdata_i;
        end else if (host_gnt) begin
            ram_a  = bus.host_addr_i;
            ram_we = bus.host_we_i;
            ram_wd = bus.host_wdata_i;
        end
    end

    always_comb begin
        last_owner_d  = last_owner_q;
        core_rvalid_d = core_gnt & ~bus.core_we_i;
        host_rvalid_d = host_gnt & ~bus.host_we_i;
        core_rdata_d  = core_rdata_q;
        host_rdata_d  = host_rdata_q;
        if (core_gnt) begin
            last_owner_d = OWN_CORE;
        end else if (host_gnt) begin
            last_owner_d = OWN_HOST;
        end
        if (core_rvalid_d) begin
            core_rdata_d = bus.ram_rd_i;
        end
        if (host_rvalid_d) begin
            host_rdata_d = bus.ram_rd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_owner_q  <= OWN_HOST;
            core_rvalid_q <= 1'b0;
            host_rvalid_q <= 1'b0;
            core_rdata_q  <= '0;
            host_rdata_q  <= '0;
        end else begin
            last_owner_q  <= last_owner_d;
            core_rvalid_q <= core_rvalid_d;
            host_rvalid_q <= host_rvalid_d;
            core_rdata_q  <= core_rdata_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    assign bus.core_gnt_o    = core_gnt;
    assign bus.host_gnt_o    = host_gnt;
    assign bus.core_rvalid_o = core_rvalid_q;
    assign bus.host_rvalid_o = host_rvalid_q;
    assign bus.core_rdata_o  = core_rdata_q;
    assign bus.host_rdata_o  = host_rdata_q;
    assign bus.ram_a_o       = ram_a;
    assign bus.ram_we_o      = ram_we;
    assign bus.ram_wd_o      = ram_wd;

`ifdef MEM_ARBITER_PERF_EN
    mem_arbiter_perf u_perf (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .core_wait_i      (bus.core_req_i & ~core_gnt),
        .host_gnt_i       (host_gnt),
        .core_stall_cnt_o (core_stall_cnt_o),
        .host_xfer_cnt_o  (host_xfer_cnt_o)
    );
`else
    assign core_stall_cnt_o = '0;
    assign host_xfer_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a behavioural RAM.
module tb_mem_arbiter;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] core_stall_cnt_o;
    logic [31:0] host_xfer_cnt_o;
    logic [31:0] mem [1024];

    int tests_run;
    int tests_failed;

    mem_arbiter_if #(.XLen(32), .MemPos(1024)) bus ();

    mem_arbiter #(.XLen(32), .MemPos(1024)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .bus              (bus),
        .core_stall_cnt_o (core_stall_cnt_o),
        .host_xfer_cnt_o  (host_xfer_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    assign bus.ram_rd_i = mem[bus.ram_a_o];
    always @(posedge clk_i) begin
        if (bus.ram_we_o) mem[bus.ram_a_o] <= bus.ram_wd_o;
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_req_i   = 1'b0;
        bus.core_we_i    = 1'b0;
        bus.core_addr_i  = '0;
        bus.core_wdata_i = '0;
        bus.host_req_i   = 1'b0;
        bus.host_we_i    = 1'b0;
        bus.host_addr_i  = '0;
        bus.host_wdata_i = '0;
        bus.host_lock_i  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        tick();
        tests_run++;
        if ({bus.core_gnt_o, bus.host_gnt_o, bus.core_rvalid_o, bus.host_rvalid_o, bus.ram_we_o} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b want 00000", {bus.core_gnt_o, bus.host_gnt_o, bus.core_rvalid_o, bus.host_rvalid_o, bus.ram_we_o});
        end
        tests_run++;
        if ({bus.core_rdata_o, bus.host_rdata_o} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h %h want 0 0", bus.core_rdata_o, bus.host_rdata_o);
        end
        tests_run++;
        if ({core_stall_cnt_o, host_xfer_cnt_o} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %0d %0d want 0 0", core_stall_cnt_o, host_xfer_cnt_o);
        end
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_core_read();
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_addr_i = 10'd5;
        #3;
        tests_run++;
        if ({bus.core_gnt_o, bus.host_gnt_o, bus.ram_we_o} !== 3'b100 || bus.ram_a_o !== 10'd5) begin
            tests_failed++;
            $display("FAIL core_read_gnt: got gnt=%b%b we=%b a=%0d want 10 0 5", bus.core_gnt_o, bus.host_gnt_o, bus.ram_we_o, bus.ram_a_o);
        end
        tick();
        bus.core_req_i = 1'b0;
        tests_run++;
        if (bus.core_rvalid_o !== 1'b1 || bus.host_rvalid_o !== 1'b0 || bus.core_rdata_o !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL core_read_data: got rv=%b hrv=%b d=%h want 1 0 deadbeef", bus.core_rvalid_o, bus.host_rvalid_o, bus.core_rdata_o);
        end
        tick();
        tests_run++;
        if (bus.core_rvalid_o !== 1'b0 || bus.core_rdata_o !== 32'hDEAD_BEEF || bus.ram_a_o !== 10'd0) begin
            tests_failed++;
            $display("FAIL core_read_hold: got rv=%b d=%h a=%0d want 0 deadbeef 0", bus.core_rvalid_o, bus.core_rdata_o, bus.ram_a_o);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] want;
        want = 8'b10_01_10_01;
        do_reset();
        bus.core_req_i  = 1'b1;
        bus.core_addr_i = 10'd5;
        bus.host_req_i  = 1'b1;
        bus.host_addr_i = 10'd5;
        for (int i = 0; i < 4; i++) begin
            #3;
            tests_run++;
            if ({bus.core_gnt_o, bus.host_gnt_o} !== want[7-2*i -: 2]) begin
                tests_failed++;
                $display("FAIL rr_cycle%0d: got %b%b want %b", i, bus.core_gnt_o, bus.host_gnt_o, want[7-2*i -: 2]);
            end
            tick();
            if (i == 0) begin
                tests_run++;
                if ({bus.core_rvalid_o, bus.host_rvalid_o} !== 2'b10) begin
                    tests_failed++;
                    $display("FAIL rr_rvalid: got %b%b want 10", bus.core_rvalid_o, bus.host_rvalid_o);
                end
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_host_lock();
        bus.host_lock_i = 1'b1;
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_addr_i = 10'd2;
        for (int i = 0; i < 4; i++) begin
            bus.host_req_i   = 1'b1;
            bus.host_we_i    = 1'b1;
            bus.host_addr_i  = 10'(i);
            bus.host_wdata_i = 32'h10 + 32'(i);
            #3;
            tests_run++;
            if ({bus.core_gnt_o, bus.host_gnt_o, bus.ram_we_o} !== 3'b011) begin
                tests_failed++;
                $display("FAIL lock_cycle%0d: got gnt=%b%b we=%b want 01 1", i, bus.core_gnt_o, bus.host_gnt_o, bus.ram_we_o);
            end
            tick();
        end
        bus.host_req_i  = 1'b0;
        bus.host_we_i   = 1'b0;
        bus.host_lock_i = 1'b0;
        #3;
        tests_run++;
        if ({bus.core_gnt_o, bus.host_rvalid_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL lock_release_gnt: got gnt=%b hrv=%b want 1 0", bus.core_gnt_o, bus.host_rvalid_o);
        end
        tick();
        bus.core_req_i = 1'b0;
        tests_run++;
        if (bus.core_rvalid_o !== 1'b1 || bus.core_rdata_o !== 32'h12) begin
            tests_failed++;
            $display("FAIL lock_read: got rv=%b d=%h want 1 00000012", bus.core_rvalid_o, bus.core_rdata_o);
        end
        tick();
    endtask

    task automatic test_coherency();
        bus.host_req_i   = 1'b1;
        bus.host_we_i    = 1'b1;
        bus.host_addr_i  = 10'd7;
        bus.host_wdata_i = 32'hA5A5_0001;
        tick();
        bus.host_req_i  = 1'b0;
        bus.host_we_i   = 1'b0;
        bus.core_req_i  = 1'b1;
        bus.core_addr_i = 10'd7;
        tests_run++;
        if (bus.host_rvalid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL coh_write_rvalid: got %b want 0", bus.host_rvalid_o);
        end
        tick();
        bus.core_req_i = 1'b0;
        tests_run++;
        if (bus.core_rvalid_o !== 1'b1 || bus.core_rdata_o !== 32'hA5A5_0001) begin
            tests_failed++;
            $display("FAIL coh_read: got rv=%b d=%h want 1 a5a50001", bus.core_rvalid_o, bus.core_rdata_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.core_req_i  = 1'b1;
        bus.core_addr_i = 10'd5;
        tick();
        bus.core_addr_i = 10'd3;
        tests_run++;
        if (bus.core_rvalid_o !== 1'b1 || bus.core_rdata_o !== 32'hDEAD_BEEF || bus.core_gnt_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first: got rv=%b d=%h gnt=%b want 1 deadbeef 1", bus.core_rvalid_o, bus.core_rdata_o, bus.core_gnt_o);
        end
        tick();
        bus.core_req_i = 1'b0;
        tests_run++;
        if (bus.core_rvalid_o !== 1'b1 || bus.core_rdata_o !== 32'h13) begin
            tests_failed++;
            $display("FAIL b2b_second: got rv=%b d=%h want 1 00000013", bus.core_rvalid_o, bus.core_rdata_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_read();
        bus.core_req_i  = 1'b1;
        bus.core_addr_i = 10'd5;
        tick();
        bus.core_req_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        tests_run++;
        if (bus.core_rvalid_o !== 1'b0 || bus.core_rdata_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL rst_mid_read: got rv=%b d=%h want 0 0", bus.core_rvalid_o, bus.core_rdata_o);
        end
        tick();
        rst_ni = 1'b1;
        bus.core_req_i = 1'b1;
        bus.host_req_i = 1'b1;
        #3;
        tests_run++;
        if ({bus.core_gnt_o, bus.host_gnt_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rst_first_tie: got %b%b want 10", bus.core_gnt_o, bus.host_gnt_o);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_perf();
        logic [31:0] want_stall, want_xfer;
`ifdef MEM_ARBITER_PERF_EN
        want_stall = 32'd3;
        want_xfer  = 32'd5;
`else
        want_stall = 32'd0;
        want_xfer  = 32'd0;
`endif
        do_reset();
        bus.host_lock_i = 1'b1;
        bus.core_req_i  = 1'b1;
        bus.core_addr_i = 10'd9;
        for (int i = 0; i < 3; i++) tick();
        bus.core_req_i = 1'b0;
        bus.host_req_i = 1'b1;
        bus.host_we_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.host_addr_i  = 10'(20 + i);
            bus.host_wdata_i = 32'(i);
            tick();
        end
        idle_inputs();
        tick();
        tests_run++;
        if (core_stall_cnt_o !== want_stall || host_xfer_cnt_o !== want_xfer) begin
            tests_failed++;
            $display("FAIL perf_cnt: got stall=%0d xfer=%0d want %0d %0d", core_stall_cnt_o, host_xfer_cnt_o, want_stall, want_xfer);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[5] = 32'hDEAD_BEEF;
        idle_inputs();
        rst_ni = 1'b0;
        test_reset();
        test_core_read();
        test_round_robin();
        test_host_lock();
        test_coherency();
        test_back_to_back();
        test_reset_mid_read();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
